transmisor_serie14: RTL
=======================

Name: transmisor_serie14

Overview:
Parallel-to-serial transmitter for 14-bit words held in the datapath's 14-bit enable-loaded registers. It accepts one word per load strobe (en/datain, same semantics as the register write side) and shifts it out as an asynchronous serial frame on txd. The frame has a start bit, 14 data bits LSB-first, optional even parity and a stop bit. It sits at the output end of the datapath, driving the board's serial pin or a matching receiver.

Parameters:
WIDTH, 14, data word width; only 14 is supported and verified.
CLKS_PER_BIT, 4, clk cycles per serial bit; legal values are 2 or more.
PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
clk  input  1  system clock, all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  load request; sampled on posedge clk.
datain  input  14  word to transmit; sampled when en && ready.
ready  output  1  high when idle and able to accept a load.
busy  output  1  high while a frame is on txd; equals ~ready.
done  output  1  one-cycle pulse after a frame's stop bit completes.
txd  output  1  serial line; idles high.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=IDLE, ready=1, busy=0, done=0, txd=1. The shift register, bit counter and baud counter all clear to 0.
- States and transitions:
  - IDLE → START on en && ready.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after 14 bit-times.
  - PARITY → STOP after 1 bit-time.
  - STOP → IDLE after 1 bit-time.
- Load: on the edge where en && ready, datain is captured into the shift register and the parity bit is latched as ^datain. From that edge, txd=0 and ready=0.
- en while busy is ignored. There is no buffering, and datain changes mid-frame have no effect.
- Bit timing: every bit, including start, parity and stop, is held on txd for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps; the bit advances on the wrap.
- DATA: txd = shreg[0]. On each bit wrap the register shifts right and the bit index increments 0..13. The index does not wrap past 13; the last bit exits DATA.
- PARITY: txd = latched even-parity bit, so the total count of 1s in data plus parity is even.
- STOP: txd = 1.
- Frame length: (16 + PARITY_EN) × CLKS_PER_BIT cycles from the load edge to the IDLE transition.
- Completion: the edge ending STOP sets state=IDLE, ready=1 and done=1. done is high for exactly that one cycle.
- Back-to-back: en high during the done cycle is accepted. The next start bit begins on the following edge, with no extra idle bit.
- txd is a registered output, so it is glitch-free.
- Reset mid-frame: txd returns to 1 immediately (asynchronously), the word is discarded and done is not pulsed. After release, the block is ready in IDLE.
- Arithmetic: baud counter width is $clog2(CLKS_PER_BIT); bit index width is 4 bits. Compares use unsigned values.

Decomposition:
- Shared header transmisor_defs.vh holds:
  - state encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - the frame-length constants.
- Sub-module divisor_baudios (parameter CLKS_PER_BIT):
  - inputs: clk, rst_n and a sync clear (asserted on load);
  - output: tick, one cycle high per bit period.
- The FSM and shift register stay in transmisor_serie14.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 cycles, then release → txd=1, ready=1, busy=0, done=0; with en=0 they stay so for 20 cycles.
2. Single frame (CLKS_PER_BIT=4, PARITY_EN=1): en=1, datain=14'h0001 → txd sequence is:
   - 0 for 4 cycles (start);
   - 1 for 4 cycles;
   - 0 for 13×4 cycles;
   - parity 1 for 4 cycles;
   - stop 1 for 4 cycles.
   done pulses at cycle 68 after the load edge.
3. Parity/data check: datain=14'h2A5B → sampled bits LSB-first are 1,1,0,1,1,0,1,0,0,1,0,1,0,1; parity bit is 0 (eight 1s). A bench receiver reconstructs 14'h2A5B.
4. Ignored load and back-to-back: pulse en with 14'h3FFF mid-frame → no effect. Then hold en=1 with 14'h3FFF through the done cycle → the second start bit begins the cycle after done, and its parity is 0.
5. Reset mid-frame: assert rst_n=0 during DATA bit 5 → txd=1 within the same cycle, done is never asserted, and ready=1 after release.
6. PARITY_EN=0, CLKS_PER_BIT=2, datain=14'h1555 → frame is 32 cycles with no parity bit, and done pulses at cycle 32.

Source files
------------

// File: rtl/transmisor_serie14_pkg.sv
// Shared definitions for the 14-bit serial transmitter: state encoding and frame-length constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package transmisor_serie14_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 14;

    // Bits on the line per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int parity_en);
        return 2 + DATA_BITS + ((parity_en != 0) ? 1 : 0);
    endfunction

    // Clock cycles from the load edge to the return to IDLE.
    function automatic int frame_cycles(input int clks_per_bit, input int parity_en);
        return frame_bits(parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/transmisor_serie14_divisor_baudios.sv
// Baud divider: free-running 0..CLKS_PER_BIT-1 counter, tick high on the last count of each bit period.
// Latency: tick first rises CLKS_PER_BIT-1 cycles after a sync clear.
// Backpressure: none; runs every cycle.
// Ports: clk, rst_n (async, active-low), clr (sync clear, asserted on load), tick (bit-period strobe).
module divisor_baudios #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/transmisor_serie14.sv
// Parallel-to-serial transmitter: start bit, 14 data bits LSB-first, optional even parity, stop bit.
// Latency: txd drops to the start bit on the load edge; done pulses (16+PARITY_EN)*CLKS_PER_BIT cycles later.
// Backpressure: en is only honoured while ready; loads while busy are dropped, nothing is buffered.
// Ports: clk, rst_n (async, active-low), en/datain (load), ready/busy (idle status), done (frame end pulse), txd (serial line).
module transmisor_serie14
    import transmisor_serie14_pkg::*;
#(
    parameter int WIDTH        = 14,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] datain,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             txd
);

    localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

    tx_state_t        state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [3:0]       bit_idx, bit_idx_nx;
    logic             par_bit, par_nx;
    logic             txd_nx, done_nx;
    logic             load, tick;

    divisor_baudios #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (load),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        par_nx     = par_bit;
        load       = 1'b0;
        done_nx    = 1'b0;
        txd_nx     = 1'b1;

        case (state)
            IDLE: begin
                if (en) begin
                    load       = 1'b1;
                    state_nx   = START;
                    shreg_nx   = datain;
                    bit_idx_nx = '0;
                    par_nx     = ^datain;
                end
            end
            START: begin
                if (tick) state_nx = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        shreg_nx   = shreg >> 1;
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // txd is registered, so it is derived from the state and data that
        // will be current after this edge.
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shreg_nx[0];
            PARITY:  txd_nx = par_nx;
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            txd     <= 1'b1;
            done    <= 1'b0;
        end else begin
            shreg   <= shreg_nx;
            bit_idx <= bit_idx_nx;
            par_bit <= par_nx;
            txd     <= txd_nx;
            done    <= done_nx;
        end
    end

    assign ready = (state == IDLE);
    assign busy  = ~ready;

endmodule
